// File: rtl/wts_timer_array.sv
// Multi-channel interval timer for the Wave Table Sound core.
// Each channel is an armed down-counter with a sticky expiry flag, overrun detection and address capture.
module wts_timer_array #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 2
) (
    input  logic                       nreset,
    input  logic                       clk,
    input  logic                       tick,
    input  logic [CH_NUM*CNT_W-1:0]    reg_reload,
    input  logic [CH_NUM-1:0]          reg_enable,
    input  logic [CH_NUM-1:0]          reg_periodic,
    input  logic [CH_NUM-1:0]          reg_int_en,
    input  logic [CH_NUM-1:0]          reg_start,
    input  logic [CH_NUM-1:0]          reg_stop,
    input  logic [CH_NUM-1:0]          reg_clear,
    input  logic [CH_NUM*ADDR_W-1:0]   cap_address,
    output logic [CH_NUM*CNT_W-1:0]    count,
    output logic [CH_NUM*(ADDR_W+3)-1:0] status,
    output logic                       nint
);

    localparam int ST_W = ADDR_W + 3;

    typedef enum logic {
        IDLE,
        ARMED
    } ch_state_t;

    logic [CH_NUM-1:0] flag;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        ch_state_t         state, state_nx;
        logic [CNT_W-1:0]  cnt, cnt_nx;
        logic [ADDR_W-1:0] addr, addr_nx;
        logic              flag_q, flag_nx;
        logic              ovr_q, ovr_nx;
        logic              run;
        logic              expire;
        logic [CNT_W-1:0]  reload;

        assign reload = reg_reload[n*CNT_W +: CNT_W];
        assign run    = (state == ARMED) && reg_enable[n] && tick;
        assign expire = run && (cnt == '0);

        // Priority: start overrides everything, expiry overrides clear, stop only gates the next state.
        always_comb begin
            // NOTE: every output gets a default first so no path can infer a latch.
            state_nx = state;
            cnt_nx   = cnt;
            addr_nx  = addr;
            flag_nx  = flag_q;
            ovr_nx   = ovr_q;

            if (reg_clear[n]) begin
                flag_nx = 1'b0;
                ovr_nx  = 1'b0;
            end

            if (reg_start[n]) begin
                state_nx = ARMED;
                cnt_nx   = reload;
            end else begin
                if (expire) begin
                    flag_nx = 1'b1;
                    ovr_nx  = reg_clear[n] ? 1'b0 : (ovr_q | flag_q);
                    addr_nx = cap_address[n*ADDR_W +: ADDR_W];
                    if (reg_periodic[n]) cnt_nx = reload;
                    else                 state_nx = IDLE;
                end else if (run && !reg_stop[n]) begin
                    cnt_nx = cnt - 1'b1;
                end
                if (reg_stop[n]) state_nx = IDLE;
            end
        end

        // NOTE: state registers use non-blocking assignments and an asynchronous active-low reset.
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                state  <= IDLE;
                cnt    <= '0;
                addr   <= '0;
                flag_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                addr   <= addr_nx;
                flag_q <= flag_nx;
                ovr_q  <= ovr_nx;
            end
        end

        assign flag[n]                   = flag_q;
        assign count[n*CNT_W +: CNT_W]   = cnt;
        assign status[n*ST_W +: ST_W]    = {flag_q, ovr_q, state == ARMED, addr};
    end

    assign nint = ~|(flag & reg_int_en);

endmodule

// File: tb/tb_wts_timer_array.sv
// Directed self-checking bench for wts_timer_array with four 8-bit channels.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_wts_timer_array;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int AW = 2;
    localparam int SW = AW + 3;

    logic              nreset;
    logic              clk;
    logic              tick;
    logic [CH*CW-1:0]  reg_reload;
    logic [CH-1:0]     reg_enable;
    logic [CH-1:0]     reg_periodic;
    logic [CH-1:0]     reg_int_en;
    logic [CH-1:0]     reg_start;
    logic [CH-1:0]     reg_stop;
    logic [CH-1:0]     reg_clear;
    logic [CH*AW-1:0]  cap_address;
    logic [CH*CW-1:0]  count;
    logic [CH*SW-1:0]  status;
    logic              nint;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    wts_timer_array #(.CH_NUM(CH), .CNT_W(CW), .ADDR_W(AW)) dut (
        .nreset       (nreset),
        .clk          (clk),
        .tick         (tick),
        .reg_reload   (reg_reload),
        .reg_enable   (reg_enable),
        .reg_periodic (reg_periodic),
        .reg_int_en   (reg_int_en),
        .reg_start    (reg_start),
        .reg_stop     (reg_stop),
        .reg_clear    (reg_clear),
        .cap_address  (cap_address),
        .count        (count),
        .status       (status),
        .nint         (nint)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CW-1:0] cnt_of(input int n);
        return count[n*CW +: CW];
    endfunction
    function automatic logic flag_of(input int n);
        return status[n*SW + AW + 2];
    endfunction
    function automatic logic ovr_of(input int n);
        return status[n*SW + AW + 1];
    endfunction
    function automatic logic armed_of(input int n);
        return status[n*SW + AW];
    endfunction
    function automatic logic [AW-1:0] addr_of(input int n);
        return status[n*SW +: AW];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [CH-1:0] m);
        reg_start = m;
        step();
        reg_start = '0;
    endtask

    task automatic idle_all();
        tick      = 1'b0;
        reg_stop  = '1;
        reg_clear = '1;
        step();
        reg_stop  = '0;
        reg_clear = '0;
    endtask

    initial begin
        nreset       = 1'b0;
        tick         = 1'b0;
        reg_reload   = '0;
        reg_enable   = '0;
        reg_periodic = '0;
        reg_int_en   = '0;
        reg_start    = '0;
        reg_stop     = '0;
        reg_clear    = '0;
        cap_address  = '0;

        #12;
        check("reset_count", count, 0);
        check("reset_status", status, 0);
        check("reset_nint", nint, 1);
        nreset = 1'b1;
        step();

        // Periodic reload=3 on channel 0
        reg_reload[0 +: CW] = 8'd3;
        reg_periodic = 4'b0001;
        reg_enable   = 4'b0001;
        reg_int_en   = 4'b0001;
        cap_address  = 8'b0000_0010;
        pulse_start(4'b0001);
        check("p3_start_count", cnt_of(0), 3);
        check("p3_start_armed", armed_of(0), 1);
        tick = 1'b1;
        step(); check("p3_cnt2", cnt_of(0), 2);
        step(); check("p3_cnt1", cnt_of(0), 1);
        step(); check("p3_cnt0", cnt_of(0), 0);
        check("p3_nint_before", nint, 1);
        cap_address = 8'b0000_0001;
        step();
        check("p3_reload", cnt_of(0), 3);
        check("p3_flag", flag_of(0), 1);
        check("p3_addr", addr_of(0), 2'b01);
        check("p3_nint", nint, 0);
        check("p3_ovr", ovr_of(0), 0);
        idle_all();
        check("p3_cleared_nint", nint, 1);
        check("p3_stop_armed", armed_of(0), 0);
        check("p3_stop_count", cnt_of(0), 3);

        // One-shot reload=1
        reg_reload[0 +: CW] = 8'd1;
        reg_periodic = 4'b0000;
        pulse_start(4'b0001);
        tick = 1'b1;
        step(); check("os_cnt0", cnt_of(0), 0);
        step();
        check("os_flag", flag_of(0), 1);
        check("os_armed", armed_of(0), 0);
        check("os_count", cnt_of(0), 0);
        repeat (10) step();
        check("os_no_rearm", armed_of(0), 0);
        check("os_no_overrun", ovr_of(0), 0);
        check("os_count_hold", cnt_of(0), 0);
        idle_all();

        // Periodic reload=0: overrun, then clear coincident with a tick
        reg_reload[0 +: CW] = 8'd0;
        reg_periodic = 4'b0001;
        pulse_start(4'b0001);
        tick = 1'b1;
        step();
        check("z_flag1", flag_of(0), 1);
        check("z_ovr1", ovr_of(0), 0);
        step();
        check("z_ovr2", ovr_of(0), 1);
        reg_clear = 4'b0001;
        step();
        reg_clear = '0;
        check("z_clr_flag", flag_of(0), 1);
        check("z_clr_ovr", ovr_of(0), 0);
        check("z_clr_nint", nint, 0);
        idle_all();
        check("z_idle_nint", nint, 1);

        // Four channels, reloads 0..3, only channel 2 unmasked
        reg_reload   = {8'd3, 8'd2, 8'd1, 8'd0};
        reg_periodic = 4'b1111;
        reg_enable   = 4'b1111;
        reg_int_en   = 4'b0100;
        pulse_start(4'b1111);
        tick = 1'b1;
        step(); check("m_tick1_nint", nint, 1);
        step(); check("m_tick2_nint", nint, 1);
        step();
        check("m_tick3_nint", nint, 0);
        check("m_ch2_flag", flag_of(2), 1);
        check("m_ch3_flag", flag_of(3), 0);
        tick      = 1'b0;
        reg_clear = 4'b0100;
        step();
        reg_clear = '0;
        check("m_clr2_nint", nint, 1);
        check("m_ch0_keep", flag_of(0), 1);
        check("m_ch1_keep", flag_of(1), 1);
        check("m_ch2_clr", flag_of(2), 0);
        reg_int_en = 4'b0001;
        #1 check("m_mask_on_nint", nint, 0);
        reg_int_en = 4'b0000;
        #1 check("m_mask_off_nint", nint, 1);
        idle_all();

        // Start on the expiry tick, then asynchronous reset mid-count
        reg_reload   = {8'd0, 8'd0, 8'd0, 8'd2};
        reg_periodic = 4'b0011;
        reg_enable   = 4'b0011;
        reg_int_en   = 4'b0010;
        pulse_start(4'b0011);
        tick = 1'b1;
        step(); check("se_cnt1", cnt_of(0), 1);
        step(); check("se_cnt0", cnt_of(0), 0);
        reg_reload[0 +: CW] = 8'd5;
        pulse_start(4'b0001);
        check("se_load", cnt_of(0), 5);
        check("se_no_flag", flag_of(0), 0);
        step();
        check("se_cnt4", cnt_of(0), 4);
        check("se_ch1_nint", nint, 0);
        #2 nreset = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_status", status, 0);
        check("ar_nint", nint, 1);
        tick      = 1'b0;
        reg_start = '0;
        #1 nreset = 1'b1;
        step();

        // Enable dropped for five ticks mid-count
        reg_reload   = {8'd0, 8'd0, 8'd0, 8'd4};
        reg_periodic = 4'b0001;
        reg_enable   = 4'b0001;
        reg_int_en   = 4'b0001;
        pulse_start(4'b0001);
        tick = 1'b1;
        step(); check("en_cnt3", cnt_of(0), 3);
        step(); check("en_cnt2", cnt_of(0), 2);
        reg_enable = 4'b0000;
        repeat (5) step();
        check("en_frozen", cnt_of(0), 2);
        check("en_frozen_flag", flag_of(0), 0);
        reg_enable = 4'b0001;
        step(); check("en_cnt1", cnt_of(0), 1);
        step();
        check("en_cnt0", cnt_of(0), 0);
        check("en_no_flag", flag_of(0), 0);
        step();
        check("en_flag", flag_of(0), 1);
        check("en_reload", cnt_of(0), 4);
        check("en_nint", nint, 0);
        idle_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
